// File: rtl/dirty_tracker_if.sv
// Port-0 access bus and flush-walker handshake between cache control and the dirty tracker.
interface dirty_tracker_if #(
  parameter int S_INDEX  = 4,
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int CNT_W    = $clog2((1 << S_INDEX) * NUM_WAYS + 1)
);
  logic                csb0;
  logic                web0;
  logic [S_INDEX-1:0]  addr0;
  logic [NUM_WAYS-1:0] wmask0;
  logic [NUM_WAYS-1:0] din0;
  logic [NUM_WAYS-1:0] dout0;
  logic [CNT_W-1:0]    dirty_count;
  logic                flush_req;
  logic                flush_busy;
  logic                flush_valid;
  logic [S_INDEX-1:0]  flush_set;
  logic [WAY_W-1:0]    flush_way;
  logic                flush_ready;
  logic                flush_done;

  modport master (
    output csb0, web0, addr0, wmask0, din0, flush_req, flush_ready,
    input  dout0, dirty_count, flush_busy, flush_valid, flush_set, flush_way, flush_done
  );

  modport slave (
    input  csb0, web0, addr0, wmask0, din0, flush_req, flush_ready,
    output dout0, dirty_count, flush_busy, flush_valid, flush_set, flush_way, flush_done
  );
endinterface

// File: rtl/dirty_tracker.sv
// Per-way dirty-bit store with masked writes, running dirty count and a flush walker
// that offers each dirty (set, way) over valid/ready and clears it on acceptance.
module dirty_tracker #(
  parameter int S_INDEX  = 4,
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int CNT_W    = $clog2((1 << S_INDEX) * NUM_WAYS + 1)
) (
  input logic             clk0,
  input logic             reset,
  dirty_tracker_if.slave  bus
);
  localparam int SETS = 1 << S_INDEX;

  typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

  state_t              state, next_state;
  logic [NUM_WAYS-1:0] rows [SETS];
  logic [NUM_WAYS-1:0] dout_q;
  logic [CNT_W-1:0]    cnt_q, next_cnt;
  logic [S_INDEX-1:0]  scan_idx, next_scan_idx;
  logic [S_INDEX-1:0]  off_set;
  logic [WAY_W-1:0]    off_way;

  logic                busy, wr_en, rd_en, accept, found, latch_offer;
  logic [NUM_WAYS-1:0] cur_row, merged, scan_row;
  logic [WAY_W-1:0]    low_way;
  logic [CNT_W-1:0]    rise_cnt, fall_cnt;

  assign busy = (state == SCAN) || (state == OFFER);

  always_comb begin
    wr_en    = bus.csb0 & bus.web0 & ~busy;
    rd_en    = bus.csb0 & ~bus.web0;
    cur_row  = rows[bus.addr0];
    merged   = (cur_row & ~bus.wmask0) | (bus.din0 & bus.wmask0);
    rise_cnt = '0;
    fall_cnt = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (bus.wmask0[i] && bus.din0[i] && !cur_row[i]) rise_cnt = rise_cnt + CNT_W'(1);
      if (bus.wmask0[i] && !bus.din0[i] && cur_row[i]) fall_cnt = fall_cnt + CNT_W'(1);
    end

    accept = (state == OFFER) && bus.flush_ready;

    // Lowest-index dirty way of the set under examination
    scan_row = rows[scan_idx];
    found    = 1'b0;
    low_way  = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (scan_row[i] && !found) begin
        found   = 1'b1;
        low_way = WAY_W'(i);
      end
    end

    // Port-0 writes are blocked while busy, so the two count updates never coincide
    next_cnt = cnt_q;
    if (wr_en)       next_cnt = cnt_q + rise_cnt - fall_cnt;
    else if (accept) next_cnt = cnt_q - CNT_W'(1);

    next_state    = state;
    next_scan_idx = scan_idx;
    latch_offer   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.flush_req) begin
          next_state    = SCAN;
          next_scan_idx = '0;
        end
      end
      SCAN: begin
        if (found) begin
          next_state  = OFFER;
          latch_offer = 1'b1;
        end else if (scan_idx == S_INDEX'(SETS - 1)) begin
          next_state = DONE;
        end else begin
          next_scan_idx = scan_idx + S_INDEX'(1);
        end
      end
      OFFER: begin
        if (bus.flush_ready) next_state = SCAN;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state    <= IDLE;
      scan_idx <= '0;
      off_set  <= '0;
      off_way  <= '0;
    end else begin
      state    <= next_state;
      scan_idx <= next_scan_idx;
      if (latch_offer) begin
        off_set <= scan_idx;
        off_way <= low_way;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) rows[s] <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= next_cnt;
      if (wr_en) begin
        rows[bus.addr0] <= merged;
        dout_q          <= merged;
      end else begin
        if (accept) rows[off_set][off_way] <= 1'b0;
        if (rd_en)  dout_q <= cur_row;
      end
    end
  end

  assign bus.dout0       = dout_q;
  assign bus.dirty_count = cnt_q;
  assign bus.flush_busy  = busy;
  assign bus.flush_valid = (state == OFFER);
  assign bus.flush_done  = (state == DONE);
  assign bus.flush_set   = off_set;
  assign bus.flush_way   = off_way;
endmodule

// File: tb/tb_dirty_tracker.sv
// Directed checks for dirty_tracker: port-0 vector table plus flush-walk sequences.
module tb_dirty_tracker;
  localparam int S_INDEX  = 4;
  localparam int NUM_WAYS = 4;

  logic clk0 = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk0 = ~clk0;

  dirty_tracker_if #(.S_INDEX(S_INDEX), .NUM_WAYS(NUM_WAYS)) bus ();

  dirty_tracker #(.S_INDEX(S_INDEX), .NUM_WAYS(NUM_WAYS)) dut (
    .clk0  (clk0),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       csb;
    logic       web;
    logic [3:0] addr;
    logic [3:0] wmask;
    logic [3:0] din;
    logic [3:0] exp_dout;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle_port();
    bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = '0; bus.wmask0 = '0; bus.din0 = '0;
  endtask

  task automatic access(input logic web, input logic [3:0] addr,
                        input logic [3:0] wmask, input logic [3:0] din);
    bus.csb0 = 1'b1; bus.web0 = web; bus.addr0 = addr; bus.wmask0 = wmask; bus.din0 = din;
    cyc();
    idle_port();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.flush_valid && n < 100) begin cyc(); n++; end
    check(name, int'(bus.flush_valid), 1);
  endtask

  initial begin
    int s_q[$];
    int w_q[$];
    int done_pulses;
    int n;
    logic [3:0] hold_set;
    logic [1:0] hold_way;

    vecs[0]  = '{1'b1, 1'b0, 4'd0,  4'b0000, 4'b0000, 4'b0000, 0};
    vecs[1]  = '{1'b1, 1'b0, 4'd15, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[2]  = '{1'b1, 1'b1, 4'd3,  4'b0101, 4'b1111, 4'b0101, 2};
    vecs[3]  = '{1'b1, 1'b1, 4'd3,  4'b0001, 4'b0000, 4'b0100, 1};
    vecs[4]  = '{1'b1, 1'b0, 4'd3,  4'b0000, 4'b0000, 4'b0100, 1};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  4'b0000, 4'b0000, 4'b0100, 1};
    vecs[6]  = '{1'b1, 1'b1, 4'd15, 4'b1111, 4'b1111, 4'b1111, 5};
    vecs[7]  = '{1'b1, 1'b1, 4'd15, 4'b1010, 4'b0101, 4'b0101, 3};
    vecs[8]  = '{1'b1, 1'b1, 4'd15, 4'b1111, 4'b0000, 4'b0000, 1};
    vecs[9]  = '{1'b1, 1'b1, 4'd3,  4'b0100, 4'b0000, 4'b0000, 0};
    vecs[10] = '{1'b0, 1'b1, 4'd4,  4'b1111, 4'b1111, 4'b0000, 0};
    vecs[11] = '{1'b1, 1'b0, 4'd4,  4'b0000, 4'b0000, 4'b0000, 0};
    vecs[12] = '{1'b1, 1'b1, 4'd2,  4'b1010, 4'b1010, 4'b1010, 2};
    vecs[13] = '{1'b1, 1'b1, 4'd9,  4'b0001, 4'b0001, 4'b0001, 3};

    reset = 1'b1;
    idle_port();
    bus.flush_req = 1'b0;
    bus.flush_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    check("reset_dout", int'(bus.dout0), 0);
    check("reset_count", int'(bus.dirty_count), 0);
    check("reset_busy", int'(bus.flush_busy), 0);
    check("reset_valid", int'(bus.flush_valid), 0);
    check("reset_done", int'(bus.flush_done), 0);
    check("reset_set_way", int'({bus.flush_set, bus.flush_way}), 0);

    foreach (vecs[i]) begin
      bus.csb0 = vecs[i].csb; bus.web0 = vecs[i].web; bus.addr0 = vecs[i].addr;
      bus.wmask0 = vecs[i].wmask; bus.din0 = vecs[i].din;
      cyc();
      check($sformatf("vec%0d_dout", i), int'(bus.dout0), int'(vecs[i].exp_dout));
      check($sformatf("vec%0d_count", i), int'(bus.dirty_count), vecs[i].exp_cnt);
    end
    idle_port();

    // Flush with ready held high: dirty (2,1), (2,3), (9,0)
    bus.flush_ready = 1'b1;
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    check("f1_busy", int'(bus.flush_busy), 1);
    done_pulses = 0;
    n = 0;
    while (n < 200 && done_pulses == 0) begin
      if (bus.flush_valid) begin s_q.push_back(int'(bus.flush_set)); w_q.push_back(int'(bus.flush_way)); end
      if (bus.flush_done) done_pulses++;
      cyc(); n++;
    end
    for (int k = 0; k < 4; k++) begin
      if (bus.flush_done) done_pulses++;
      cyc();
    end
    check("f1_offers", s_q.size(), 3);
    if (s_q.size() == 3) begin
      check("f1_o0", s_q[0] * 4 + w_q[0], 2 * 4 + 1);
      check("f1_o1", s_q[1] * 4 + w_q[1], 2 * 4 + 3);
      check("f1_o2", s_q[2] * 4 + w_q[2], 9 * 4 + 0);
    end
    check("f1_done_pulses", done_pulses, 1);
    check("f1_count", int'(bus.dirty_count), 0);

    // Stalled offer, dropped write, honoured read
    bus.flush_ready = 1'b0;
    access(1'b1, 4'd5, 4'b1111, 4'b0011);
    check("f2_pre_count", int'(bus.dirty_count), 2);
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    wait_valid("f2_valid_rise");
    hold_set = bus.flush_set;
    hold_way = bus.flush_way;
    check("f2_offer", int'({hold_set, hold_way}), (5 << 2) | 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.addr0 = 4'd5; bus.wmask0 = 4'b1111; bus.din0 = 4'b1100; end
      else if (k == 2) begin bus.csb0 = 1'b1; bus.web0 = 1'b0; bus.addr0 = 4'd5; end
      else idle_port();
      cyc();
      check($sformatf("f2_hold%0d", k),
            int'({bus.flush_valid, bus.flush_set, bus.flush_way}), int'({1'b1, hold_set, hold_way}));
      if (k == 2) check("f2_read_during_walk", int'(bus.dout0), 4'b0011);
    end
    idle_port();
    check("f2_count_after_drop", int'(bus.dirty_count), 2);
    bus.flush_ready = 1'b1;
    n = 0;
    while (!bus.flush_done && n < 100) begin cyc(); n++; end
    check("f2_done", int'(bus.flush_done), 1);
    cyc();
    access(1'b0, 4'd5, 4'b0000, 4'b0000);
    check("f2_set5_after", int'(bus.dout0), 0);
    check("f2_count_after", int'(bus.dirty_count), 0);

    // Empty array: done exactly 17 cycles after the request edge
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    n = 1;
    s_q.delete();
    while (!bus.flush_done && n < 40) begin
      if (bus.flush_valid) s_q.push_back(n);
      cyc(); n++;
    end
    check("f3_done_latency", n, 17);
    check("f3_no_valid", s_q.size(), 0);
    check("f3_busy_at_done", int'(bus.flush_busy), 0);
    cyc();
    check("f3_done_one_cycle", int'(bus.flush_done), 0);

    // Reset during OFFER aborts the walk
    bus.flush_ready = 1'b0;
    access(1'b1, 4'd7, 4'b0010, 4'b0010);
    access(1'b1, 4'd12, 4'b1000, 4'b1000);
    check("f4_pre_count", int'(bus.dirty_count), 2);
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    wait_valid("f4_valid_rise");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("f4_valid", int'(bus.flush_valid), 0);
    check("f4_busy", int'(bus.flush_busy), 0);
    check("f4_count", int'(bus.dirty_count), 0);
    done_pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.flush_done) done_pulses++;
      cyc();
    end
    check("f4_no_done", done_pulses, 0);
    access(1'b0, 4'd7, 4'b0000, 4'b0000);
    check("f4_set7", int'(bus.dout0), 0);
    access(1'b0, 4'd12, 4'b0000, 4'b0000);
    check("f4_set12", int'(bus.dout0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
